// File: rtl/scurve_sweep_ctrl.sv
// S-curve threshold sweep controller: steps the trigger DAC, runs the per-channel
// measurement and frames count words into the readout FIFO. Optional macro: SCURVE_WORD_CHECK_EN.
module scurve_sweep_ctrl #(
  parameter int CHN_NUM   = 64,
  parameter int DAC_WIDTH = 10
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 Sweep_Start,
  input  logic                 Sweep_Stop,
  input  logic [DAC_WIDTH-1:0] Start_Dac,
  input  logic [DAC_WIDTH-1:0] End_Dac,
  input  logic [DAC_WIDTH-1:0] Dac_Step,
  input  logic                 Single_Chn_Mode,
  input  logic [5:0]           Single_Chn_Sel,
  output logic [DAC_WIDTH-1:0] Dac_Code,
  output logic                 Dac_Load,
  input  logic                 Dac_Load_Done,
  output logic [5:0]           Channel_Sel,
  output logic                 SCurve_Test_Start,
  input  logic                 One_Channel_Done,
  input  logic [15:0]          SCurve_Data,
  input  logic                 SCurve_Data_wr_en,
  output logic [15:0]          Out_Data,
  output logic                 Out_Data_wr_en,
  input  logic                 Out_Fifo_Full,
  output logic                 Sweep_Busy,
  output logic                 Sweep_Done,
  output logic                 Overflow_Err,
  output logic                 Word_Cnt_Err
);

  typedef enum logic [3:0] {
    IDLE, DAC_SET, DAC_WAIT, DAC_HDR, CHN_HDR,
    CHN_START, CHN_WAIT, NEXT, TRAILER, DONE
  } state_t;

  localparam logic [5:0] LAST_CHN = 6'(CHN_NUM - 1);

  state_t               state;
  logic                 stop_latched;
  logic                 done_prev;
  logic                 done_edge;
  logic [DAC_WIDTH:0]   dac_next;

  // Widened sum so a step past the top of the code range ends the sweep instead of wrapping.
  function automatic logic [DAC_WIDTH:0] next_code(input logic [DAC_WIDTH-1:0] code,
                                                   input logic [DAC_WIDTH-1:0] step);
    logic [DAC_WIDTH-1:0] s;
    s = (step == '0) ? DAC_WIDTH'(1) : step;
    return {1'b0, code} + {1'b0, s};
  endfunction

  assign dac_next  = next_code(Dac_Code, Dac_Step);
  assign done_edge = One_Channel_Done & ~done_prev;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      stop_latched      <= 1'b0;
      done_prev         <= 1'b0;
      Dac_Code          <= '0;
      Dac_Load          <= 1'b0;
      Channel_Sel       <= '0;
      SCurve_Test_Start <= 1'b0;
      Out_Data          <= '0;
      Out_Data_wr_en    <= 1'b0;
      Sweep_Busy        <= 1'b0;
      Sweep_Done        <= 1'b0;
      Overflow_Err      <= 1'b0;
    end else begin
      done_prev         <= One_Channel_Done;
      Dac_Load          <= 1'b0;
      SCurve_Test_Start <= 1'b0;
      Sweep_Done        <= 1'b0;
      Out_Data_wr_en    <= 1'b0;
      if (Sweep_Stop) stop_latched <= 1'b1;

      // Count words are forwarded in any state; they never coincide with header writes.
      if (SCurve_Data_wr_en) begin
        if (Out_Fifo_Full) begin
          Overflow_Err <= 1'b1;
        end else begin
          Out_Data       <= SCurve_Data;
          Out_Data_wr_en <= 1'b1;
        end
      end

      case (state)
        IDLE: if (Sweep_Start) begin
          Dac_Code     <= Start_Dac;
          stop_latched <= 1'b0;
          Overflow_Err <= 1'b0;
          Sweep_Busy   <= 1'b1;
          state        <= DAC_SET;
        end
        DAC_SET: begin
          Dac_Load <= 1'b1;
          state    <= DAC_WAIT;
        end
        DAC_WAIT: if (Dac_Load_Done) state <= DAC_HDR;
        DAC_HDR: if (!Out_Fifo_Full) begin
          Out_Data       <= 16'hE000 | 16'(Dac_Code);
          Out_Data_wr_en <= 1'b1;
          Channel_Sel    <= Single_Chn_Mode ? Single_Chn_Sel : 6'd0;
          state          <= CHN_HDR;
        end
        CHN_HDR: if (!Out_Fifo_Full) begin
          Out_Data       <= 16'hC000 | 16'(Channel_Sel);
          Out_Data_wr_en <= 1'b1;
          state          <= CHN_START;
        end
        CHN_START: begin
          SCurve_Test_Start <= 1'b1;
          state             <= CHN_WAIT;
        end
        CHN_WAIT: if (done_edge) state <= NEXT;
        NEXT: begin
          if (stop_latched) begin
            state <= TRAILER;
          end else if (!Single_Chn_Mode && Channel_Sel < LAST_CHN) begin
            Channel_Sel <= Channel_Sel + 6'd1;
            state       <= CHN_HDR;
          end else if (dac_next > {1'b0, End_Dac}) begin
            state <= TRAILER;
          end else begin
            Dac_Code <= dac_next[DAC_WIDTH-1:0];
            state    <= DAC_SET;
          end
        end
        TRAILER: if (!Out_Fifo_Full) begin
          Out_Data       <= 16'hFF45;
          Out_Data_wr_en <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          Sweep_Done <= 1'b1;
          Sweep_Busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCURVE_WORD_CHECK_EN
  logic [2:0] word_cnt;
  logic [2:0] word_cnt_inc;

  // Includes a word arriving on the same cycle as the done edge; saturates at 7.
  assign word_cnt_inc = (SCurve_Data_wr_en && word_cnt != 3'd7) ? word_cnt + 3'd1 : word_cnt;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      word_cnt     <= '0;
      Word_Cnt_Err <= 1'b0;
    end else begin
      word_cnt <= (state == CHN_START) ? 3'd0 : word_cnt_inc;
      if (state == IDLE && Sweep_Start)
        Word_Cnt_Err <= 1'b0;
      else if (state == CHN_WAIT && done_edge && word_cnt_inc != 3'd6)
        Word_Cnt_Err <= 1'b1;
    end
  end
`else
  assign Word_Cnt_Err = 1'b0;
`endif

endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
// Directed bench for scurve_sweep_ctrl with loader and measurement responders.
module tb_scurve_sweep_ctrl;
  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        Sweep_Start = 1'b0;
  logic        Sweep_Stop = 1'b0;
  logic [9:0]  Start_Dac = '0;
  logic [9:0]  End_Dac = '0;
  logic [9:0]  Dac_Step = '0;
  logic        Single_Chn_Mode = 1'b0;
  logic [5:0]  Single_Chn_Sel = '0;
  logic [9:0]  Dac_Code;
  logic        Dac_Load;
  logic        Dac_Load_Done;
  logic [5:0]  Channel_Sel;
  logic        SCurve_Test_Start;
  logic        One_Channel_Done;
  logic [15:0] SCurve_Data;
  logic        SCurve_Data_wr_en;
  logic [15:0] Out_Data;
  logic        Out_Data_wr_en;
  logic        Out_Fifo_Full;
  logic        Sweep_Busy;
  logic        Sweep_Done;
  logic        Overflow_Err;
  logic        Word_Cnt_Err;

  logic        full_model = 1'b0;
  logic        full_main = 1'b0;
  logic        full_on_second = 1'b0;
  int          nwords = 6;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int          done_cnt = 0;
  int          total = 0;
  int          bad = 0;

  assign Out_Fifo_Full = full_model | full_main;

  scurve_sweep_ctrl #(.CHN_NUM(4), .DAC_WIDTH(10)) dut (
    .Clk(Clk), .reset(reset), .Sweep_Start(Sweep_Start), .Sweep_Stop(Sweep_Stop),
    .Start_Dac(Start_Dac), .End_Dac(End_Dac), .Dac_Step(Dac_Step),
    .Single_Chn_Mode(Single_Chn_Mode), .Single_Chn_Sel(Single_Chn_Sel),
    .Dac_Code(Dac_Code), .Dac_Load(Dac_Load), .Dac_Load_Done(Dac_Load_Done),
    .Channel_Sel(Channel_Sel), .SCurve_Test_Start(SCurve_Test_Start),
    .One_Channel_Done(One_Channel_Done), .SCurve_Data(SCurve_Data),
    .SCurve_Data_wr_en(SCurve_Data_wr_en), .Out_Data(Out_Data),
    .Out_Data_wr_en(Out_Data_wr_en), .Out_Fifo_Full(Out_Fifo_Full),
    .Sweep_Busy(Sweep_Busy), .Sweep_Done(Sweep_Done),
    .Overflow_Err(Overflow_Err), .Word_Cnt_Err(Word_Cnt_Err)
  );

  always #5 Clk = ~Clk;

  // Slow-control loader: acknowledges three cycles after a load request.
  initial begin
    Dac_Load_Done = 1'b0;
    forever begin
      @(negedge Clk);
      if (Dac_Load === 1'b1) begin
        repeat (2) @(negedge Clk);
        Dac_Load_Done = 1'b1;
        @(negedge Clk);
        Dac_Load_Done = 1'b0;
      end
    end
  end

  // Measurement block: nwords count words A000+k, then a done level for two cycles.
  initial begin
    SCurve_Data = '0;
    SCurve_Data_wr_en = 1'b0;
    One_Channel_Done = 1'b0;
    forever begin
      @(negedge Clk);
      if (SCurve_Test_Start === 1'b1) begin
        repeat (2) @(negedge Clk);
        for (int k = 0; k < nwords; k++) begin
          SCurve_Data = 16'hA000 + 16'(k);
          SCurve_Data_wr_en = 1'b1;
          full_model = full_on_second && (k == 1);
          @(negedge Clk);
        end
        SCurve_Data_wr_en = 1'b0;
        full_model = 1'b0;
        repeat (2) @(negedge Clk);
        One_Channel_Done = 1'b1;
        repeat (2) @(negedge Clk);
        One_Channel_Done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (Out_Data_wr_en === 1'b1) got.push_back(Out_Data);
      if (Sweep_Done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_dac"}, 32'(Dac_Code), 32'd0);
    check({tag, "_out"}, {15'd0, Out_Data, Out_Data_wr_en}, 32'd0);
    check({tag, "_ctl"}, {20'd0, Dac_Load, Channel_Sel, SCurve_Test_Start, Sweep_Busy,
                          Sweep_Done, Overflow_Err, Word_Cnt_Err}, 32'd0);
  endtask

  task automatic push_chan(input int ch, input int n, input int skip);
    exp_q.push_back(16'hC000 | 16'(ch));
    for (int k = 0; k < n; k++)
      if (k != skip) exp_q.push_back(16'hA000 + 16'(k));
  endtask

  task automatic check_seq(input string tag, input int base);
    check({tag, "_len"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), 32'(got[base+i]), 32'(exp_q[i]));
  endtask

  task automatic setup(input logic single, input logic [5:0] sel, input logic [9:0] s,
                       input logic [9:0] e, input logic [9:0] st);
    Single_Chn_Mode = single;
    Single_Chn_Sel = sel;
    Start_Dac = s;
    End_Dac = e;
    Dac_Step = st;
    exp_q.delete();
  endtask

  task automatic start_sweep(output int base, output int d0);
    base = got.size();
    d0 = done_cnt;
    Sweep_Start = 1'b1;
    @(negedge Clk);
    Sweep_Start = 1'b0;
    check("busy_after_start", 32'(Sweep_Busy), 32'd1);
    check("load_early", 32'(Dac_Load), 32'd0);
    @(negedge Clk);
    check("load_latency", 32'(Dac_Load), 32'd1);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge Clk);
      n++;
    end
    check("sweep_done_seen", 32'(done_cnt - d0), 32'd1);
    repeat (3) @(negedge Clk);
    check("sweep_done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_idle", 32'(Sweep_Busy), 32'd0);
  endtask

  task automatic wait_word(input logic [15:0] w, input logic [15:0] mask);
    int n;
    n = 0;
    while (!(Out_Data_wr_en === 1'b1 && (Out_Data & mask) == w) && n < 4000) begin
      @(negedge Clk);
      n++;
    end
    check("word_wait", 32'(n < 4000), 32'd1);
  endtask

  initial begin
    int base;
    int d0;
    int nh;
    logic [15:0] hdr[$];

    repeat (3) @(negedge Clk);
    check_rst("reset");
    reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Full multi-channel sweep over three DAC points.
    setup(1'b0, 6'd0, 10'd100, 10'd102, 10'd1);
    for (int d = 100; d <= 102; d++) begin
      exp_q.push_back(16'hE000 | 16'(d));
      for (int ch = 0; ch < 4; ch++) push_chan(ch, 6, -1);
    end
    exp_q.push_back(16'hFF45);
    start_sweep(base, d0);
    wait_done(d0);
    check_seq("multi", base);
    check("multi_ovf", 32'(Overflow_Err), 32'd0);
    check("multi_wce", 32'(Word_Cnt_Err), 32'd0);
    check("multi_dac", 32'(Dac_Code), 32'd102);

    // Single-channel mode.
    setup(1'b1, 6'd17, 10'd200, 10'd200, 10'd1);
    exp_q.push_back(16'hE0C8);
    push_chan(17, 6, -1);
    exp_q.push_back(16'hFF45);
    start_sweep(base, d0);
    wait_done(d0);
    check_seq("single", base);
    check("single_chsel", 32'(Channel_Sel), 32'd17);

    // Zero step behaves as one.
    setup(1'b1, 6'd0, 10'd10, 10'd12, 10'd0);
    start_sweep(base, d0);
    wait_done(d0);
    hdr.delete();
    for (int i = base; i < got.size(); i++)
      if (got[i][15:12] == 4'hE) hdr.push_back(got[i]);
    nh = hdr.size();
    check("step0_hdrs", 32'(nh), 32'd3);
    for (int i = 0; i < nh && i < 3; i++)
      check($sformatf("step0_hdr[%0d]", i), 32'(hdr[i]), 32'(16'hE00A + 16'(i)));

    // Start above end: one point only.
    setup(1'b1, 6'd1, 10'd12, 10'd10, 10'd1);
    exp_q.push_back(16'hE00C);
    push_chan(1, 6, -1);
    exp_q.push_back(16'hFF45);
    start_sweep(base, d0);
    wait_done(d0);
    check_seq("rev", base);
    check("rev_dac", 32'(Dac_Code), 32'd12);

    // FIFO full during the second count word drops it.
    setup(1'b1, 6'd2, 10'd50, 10'd50, 10'd1);
    exp_q.push_back(16'hE032);
    push_chan(2, 6, 1);
    exp_q.push_back(16'hFF45);
    full_on_second = 1'b1;
    start_sweep(base, d0);
    wait_done(d0);
    full_on_second = 1'b0;
    check_seq("ovf", base);
    check("ovf_flag", 32'(Overflow_Err), 32'd1);

    // FIFO full while the channel header is pending delays it.
    setup(1'b1, 6'd3, 10'd5, 10'd5, 10'd1);
    exp_q.push_back(16'hE005);
    push_chan(3, 6, -1);
    exp_q.push_back(16'hFF45);
    start_sweep(base, d0);
    check("ovf_cleared", 32'(Overflow_Err), 32'd0);
    wait_word(16'hE000, 16'hF000);
    full_main = 1'b1;
    repeat (4) @(negedge Clk);
    check("hdr_held", 32'(got.size() - base), 32'd1);
    full_main = 1'b0;
    wait_done(d0);
    check_seq("hdrfull", base);

    // Stop request during channel 1.
    setup(1'b0, 6'd0, 10'd100, 10'd102, 10'd1);
    exp_q.push_back(16'hE064);
    push_chan(0, 6, -1);
    push_chan(1, 6, -1);
    exp_q.push_back(16'hFF45);
    start_sweep(base, d0);
    wait_word(16'hC001, 16'hFFFF);
    repeat (4) @(negedge Clk);
    Sweep_Stop = 1'b1;
    @(negedge Clk);
    Sweep_Stop = 1'b0;
    wait_done(d0);
    check_seq("stop", base);

    // Short channel: five words.
    setup(1'b1, 6'd0, 10'd7, 10'd7, 10'd1);
    nwords = 5;
    start_sweep(base, d0);
    wait_done(d0);
    nwords = 6;
`ifdef SCURVE_WORD_CHECK_EN
    check("wordcnt_err", 32'(Word_Cnt_Err), 32'd1);
`else
    check("wordcnt_err", 32'(Word_Cnt_Err), 32'd0);
`endif
    check("short_len", 32'(got.size() - base), 32'd8);

    // Asynchronous reset mid-sweep.
    setup(1'b0, 6'd0, 10'd100, 10'd102, 10'd1);
    start_sweep(base, d0);
    wait_word(16'hC002, 16'hFFFF);
    reset = 1'b1;
    #1;
    check_rst("midrst");
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b0;
    repeat (60) @(negedge Clk);
    check("midrst_busy", 32'(Sweep_Busy), 32'd0);
    check("midrst_nodone", 32'(done_cnt - d0), 32'd0);
    nh = 0;
    for (int i = base; i < got.size(); i++)
      if (got[i] == 16'hFF45) nh++;
    check("midrst_notrailer", 32'(nh), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
